// File: rtl/alu_serial_ctrl_pkg.sv
// rtl/alu_serial_ctrl_pkg.sv - shared constants, state encoding and opcode decode for the serial ALU
package alu_serial_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic       a_invert;
        logic       b_invert;
        logic [1:0] operation;
        logic       cin0;
    } slice_ctrl_t;

    function automatic logic op_legal(input logic [3:0] op);
        return (op == ALU_AND) || (op == ALU_OR)  || (op == ALU_ADD) ||
               (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_NOR);
    endfunction

    // Slice control word for each opcode; illegal codes decode to a harmless AND.
    function automatic slice_ctrl_t op_decode(input logic [3:0] op);
        slice_ctrl_t c;
        c = '{a_invert: 1'b0, b_invert: 1'b0, operation: 2'b00, cin0: 1'b0};
        case (op)
            ALU_OR:  c.operation = 2'b01;
            ALU_ADD: c.operation = 2'b10;
            ALU_SUB: c = '{a_invert: 1'b0, b_invert: 1'b1, operation: 2'b10, cin0: 1'b1};
            ALU_SLT: c = '{a_invert: 1'b0, b_invert: 1'b1, operation: 2'b11, cin0: 1'b1};
            ALU_NOR: c = '{a_invert: 1'b1, b_invert: 1'b1, operation: 2'b00, cin0: 1'b0};
            default: c.operation = 2'b00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// rtl/alu_serial_ctrl_if.sv - request/response bundle between an ALU client and the serial ALU
interface alu_serial_ctrl_if;
    import alu_serial_ctrl_pkg::*;

    logic              start;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [3:0]        ALU_control;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              cout;
    logic              overflow;
    logic              busy;
    logic              done;

    modport master (
        output start, src1, src2, ALU_control,
        input  result, zero, cout, overflow, busy, done
    );

    modport slave (
        input  start, src1, src2, ALU_control,
        output result, zero, cout, overflow, busy, done
    );

endinterface

// File: rtl/alu_top.sv
// rtl/alu_top.sv - 1-bit ALU slice with operand inversion, carry chain and less input
module alu_top (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       less,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic [1:0] operation,
    output logic       result,
    output logic       cout,
    output logic       sum
);

    logic aa;
    logic bb;

    assign aa   = a ^ a_invert;
    assign bb   = b ^ b_invert;
    assign sum  = aa ^ bb ^ cin;
    assign cout = (aa & bb) | (aa & cin) | (bb & cin);

    // Output mux: AND, OR, adder sum or the externally supplied less bit.
    always_comb begin
        result = 1'b0;
        case (operation)
            2'b00:   result = aa & bb;
            2'b01:   result = aa | bb;
            2'b10:   result = sum;
            default: result = less;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// rtl/alu_serial_ctrl.sv - bit-serial 32-bit ALU controller around a single 1-bit slice
module alu_serial_ctrl
    import alu_serial_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    alu_serial_ctrl_if.slave bus
);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              carry;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [3:0]        op_q;
    logic [DATA_W-2:0] res_sr;
    logic [DATA_W-1:0] result_q;
    logic              cout_q;
    logic              ovf_q;
    slice_ctrl_t       ctrl;
    logic              s_res;
    logic              s_cout;
    logic              s_sum;
    logic              last_bit;

    assign ctrl     = op_decode(op_q);
    assign last_bit = (cnt == CNT_W'(DATA_W - 1));

    alu_top u_slice (
        .a         (a_q[cnt]),
        .b         (b_q[cnt]),
        .cin       (carry),
        .less      (1'b0),
        .a_invert  (ctrl.a_invert),
        .b_invert  (ctrl.b_invert),
        .operation (ctrl.operation),
        .result    (s_res),
        .cout      (s_cout),
        .sum       (s_sum)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = op_legal(bus.ALU_control) ? RUN : FIN;
            RUN:  if (last_bit)  state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, serial datapath and final flag capture (carry is c31 at the last bit,
    // the slice carry out is c32).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            carry    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= ALU_AND;
            res_sr   <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (op_legal(bus.ALU_control)) begin
                            a_q   <= bus.src1;
                            b_q   <= bus.src2;
                            op_q  <= bus.ALU_control;
                            cnt   <= '0;
                            carry <= op_decode(bus.ALU_control).cin0;
                        end else begin
                            result_q <= '0;
                            cout_q   <= 1'b0;
                            ovf_q    <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    carry <= s_cout;
                    if (!last_bit) begin
                        res_sr[cnt] <= s_res;
                        cnt         <= cnt + CNT_W'(1);
                    end else begin
                        case (op_q)
                            ALU_ADD, ALU_SUB: begin
                                result_q <= {s_res, res_sr};
                                cout_q   <= s_cout;
                                ovf_q    <= carry ^ s_cout;
                            end
                            ALU_SLT: begin
                                result_q <= {{(DATA_W-1){1'b0}}, s_sum ^ (carry ^ s_cout)};
                                cout_q   <= s_cout;
                                ovf_q    <= 1'b0;
                            end
                            default: begin
                                result_q <= {s_res, res_sr};
                                cout_q   <= 1'b0;
                                ovf_q    <= 1'b0;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result   = result_q;
    assign bus.zero     = (result_q == '0);
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == FIN);

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb/tb_alu_serial_ctrl.sv - self-checking bench for alu_serial_ctrl
module tb_alu_serial_ctrl;
    import alu_serial_ctrl_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
        int          lat;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    vec_t exp_q[$];
    vec_t tbl[$];

    alu_serial_ctrl_if bus();

    alu_serial_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        logic [32:0] s;
        v.op = op; v.a = a; v.b = b; v.c = 1'b0; v.v = 1'b0; v.lat = 33; v.res = '0;
        case (op)
            ALU_AND: v.res = a & b;
            ALU_OR:  v.res = a | b;
            ALU_NOR: v.res = ~(a | b);
            ALU_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                v.res = s[31:0]; v.c = s[32];
                v.v = (a[31] == b[31]) && (s[31] != a[31]);
            end
            ALU_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                v.res = s[31:0]; v.c = s[32];
                v.v = (a[31] != b[31]) && (s[31] != a[31]);
            end
            ALU_SLT: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                v.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                v.c = s[32];
            end
            default: v.lat = 1;
        endcase
        v.z = (v.res == 32'd0);
        return v;
    endfunction

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic z, input logic c, input logic v,
                                input int lat);
        vec_t r;
        r.op = op; r.a = a; r.b = b; r.res = res; r.z = z; r.c = c; r.v = v; r.lat = lat;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic do_op(input vec_t v, input bit disturb);
        int   edges;
        bit   seen;
        vec_t e;
        bus.start = 1'b1; bus.src1 = v.a; bus.src2 = v.b; bus.ALU_control = v.op;
        exp_q.push_back(v);
        edges = 0; seen = 0;
        while (!seen && edges < 60) begin
            @(posedge clk); edges++;
            @(negedge clk);
            bus.start = (disturb && edges == 10);
            bus.src1 = $urandom; bus.src2 = $urandom; bus.ALU_control = 4'($urandom);
            if (bus.done) seen = 1;
        end
        bus.start = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        e = exp_q.pop_front();
        check("latency", 32'(edges), 32'(e.lat));
        check("result", bus.result, e.res);
        check("zero", 32'(bus.zero), 32'(e.z));
        check("cout", 32'(bus.cout), 32'(e.c));
        check("overflow", 32'(bus.overflow), 32'(e.v));
        check("busy_fin", 32'(bus.busy), 32'd1);
    endtask

    initial begin
        vec_t v;
        int   dseen;
        logic [31:0] held;
        n_vec = 0; n_err = 0;
        rst = 1'b1; bus.start = 1'b0; bus.src1 = '0; bus.src2 = '0; bus.ALU_control = '0;

        tbl.push_back(mk(ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 33));
        tbl.push_back(mk(ALU_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1, 1, 0, 33));
        tbl.push_back(mk(ALU_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 1, 0, 33));
        tbl.push_back(mk(ALU_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 0, 1, 0, 33));
        tbl.push_back(mk(ALU_SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1, 0, 0, 33));
        tbl.push_back(mk(ALU_NOR, 32'h0F0F0F0F, 32'h00FF00FF, 32'hF000F000, 0, 0, 0, 33));
        tbl.push_back(mk(ALU_AND, 32'h0F0F0F0F, 32'h00FF00FF, 32'h000F000F, 0, 0, 0, 33));
        tbl.push_back(mk(ALU_OR,  32'h0F0F0F0F, 32'h00FF00FF, 32'h0FFF0FFF, 0, 0, 0, 33));
        tbl.push_back(mk(ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0, 33));
        tbl.push_back(mk(ALU_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0, 0, 0, 33));
        tbl.push_back(mk(ALU_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 1, 33));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_result", bus.result, 32'd0);
        check("rst_zero", 32'(bus.zero), 32'd1);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);

        // Directed table, each op issued in the first IDLE cycle after the previous FIN.
        for (int i = 0; i < tbl.size(); i++) begin
            do_op(tbl[i], 1'b0);
            held = bus.result;
            @(negedge clk);
            check("idle_done", 32'(bus.done), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
            check("idle_hold", bus.result, held);
        end

        // Random operands on legal opcodes against the arithmetic model.
        for (int i = 0; i < 12; i++) begin
            logic [3:0] ops [6];
            ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR};
            do_op(model(ops[$urandom_range(5)], $urandom, $urandom), 1'b0);
            @(negedge clk);
        end

        // Start pulse mid-operation with new operands must be ignored.
        do_op(model(ALU_ADD, 32'h12345678, 32'h11111111), 1'b1);
        dseen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) dseen++;
        end
        check("no_queued_op", 32'(dseen), 32'd0);

        // Reset at RUN cycle 20 aborts the operation with no done pulse.
        bus.start = 1'b1; bus.src1 = 32'd100; bus.src2 = 32'd23; bus.ALU_control = ALU_ADD;
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_result", bus.result, 32'd0);
        check("abort_zero", 32'(bus.zero), 32'd1);
        check("abort_cout", 32'(bus.cout), 32'd0);
        check("abort_overflow", 32'(bus.overflow), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        dseen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dseen++;
        end
        check("abort_no_done", 32'(dseen), 32'd0);

        // Load a nonzero result, then an illegal opcode must clear it in one cycle.
        do_op(model(ALU_OR, 32'h00F0, 32'h0F00), 1'b0);
        @(negedge clk);
        v = mk(4'b0101, 32'hDEADBEEF, 32'h1, 32'h0, 1, 0, 0, 1);
        do_op(v, 1'b0);
        // Start during FIN is dropped; the ADD in the following IDLE cycle is taken.
        bus.start = 1'b1; bus.src1 = 32'd7; bus.src2 = 32'd7; bus.ALU_control = ALU_ADD;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("fin_start_ignored", 32'(bus.busy), 32'd0);
        do_op(mk(ALU_ADD, 32'd2, 32'd3, 32'd5, 0, 0, 0, 33), 1'b0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
